cordic_nco_ctrl: RTL
====================

Name: cordic_nco_ctrl

Overview:
Numerically-controlled-oscillator front end for the cordic_core_v2 sine/cosine engine.
- Holds a phase accumulator and turns sample requests into CORDIC start pulses with a phase argument.
- Waits for the engine's finish pulse, then registers its sin/cos results with a one-cycle valid strobe.
- Sits directly upstream and downstream of the core and owns its start/finish handshake.

Parameters:
W, 16, angle/sample width; must equal the core's w
FW, 32, phase accumulator / frequency word width (FW >= W)
TMO, 32, maximum cycles to wait for finish before aborting

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (core's active-high reset is derived by inversion at integration)
enable  in  1  high = sample ticks accepted
sample_tick  in  1  one-cycle request for a new sample
freq_word  in  FW  phase increment per sample, unsigned, sampled on accepted tick
load_phase  in  1  one-cycle load of accumulator
phase_init  in  W  value loaded into accumulator top W bits (low FW-W bits cleared)
phase_offset  in  W  added to accumulator top bits to form argument (mod 2^W)
clr_flags  in  1  clears sticky overrun/timeout
cordic_start  out  1  start pulse to core
cordic_z0  out  W  signed argument to core, held stable from start until finish
cordic_finish  in  1  core finish
cordic_sin  in  W  core sin result
cordic_cos  in  W  core cos result
sin_out  out  W  registered sine sample
cos_out  out  W  registered cosine sample
out_valid  out  1  one-cycle strobe, sin_out/cos_out updated same cycle
busy  out  1  high in ISSUE or WAIT
overrun  out  1  sticky: tick dropped
timeout  out  1  sticky: finish not seen within TMO cycles

Behaviour:
Reset values:
- All outputs, accumulator, pending flag and timer = 0.
- State = IDLE.
- Reset mid-conversion aborts it; no out_valid is produced.

States:
- IDLE -> ISSUE on an accepted tick (enable=1 and either sample_tick or pending).
- ISSUE: cordic_start=1 for exactly one cycle. Next state is WAIT. Timer cleared.
- WAIT:
  - cordic_finish=1: capture cordic_sin/cordic_cos into sin_out/cos_out, out_valid=1, go to IDLE.
  - timer reaches TMO-1 without finish: set timeout, go to IDLE, no out_valid.

Argument formation, on an accepted tick:
- p = acc[FW-1 -: W] + phase_offset, wrap mod 2^W.
- If p == 1 followed by W-1 zeros (most-negative), substitute 1 followed by W-2 zeros then 1 (e.g. 16'h8000 -> 16'h8001). This avoids negation overflow in the core.
- cordic_z0 <= p, then acc <= acc + freq_word (wraps mod 2^FW).

load_phase:
- Has priority over the accumulator update.
- A tick in the same cycle uses phase_init as the accumulator top bits.
- acc ends as {phase_init, 0} + freq_word.

Tick while busy:
- If pending=0, set pending.
- If pending=1, the tick is dropped and overrun is set.
- A pending tick is issued in the cycle after return to IDLE, giving ISSUE at IDLE+1.

Other rules:
- out_valid and a new tick in the same cycle: both honoured.
- Latency: tick at cycle T -> cordic_start at T+1. out_valid arrives one cycle after the core's finish, which is about 18 cycles after start for w=16.
- enable=0: new ticks are ignored and pending is cleared. An in-flight conversion completes normally.
- clr_flags clears overrun/timeout. A set event in the same cycle wins.
- Spurious cordic_finish in IDLE/ISSUE is ignored.

Decomposition:
Shared package cordic_pkg holds:
- W default
- angle constants: ANG_MOST_NEG = 16'h8000, ANG_CLAMP = 16'h8001, quarter-turn 16'h4000
- state encoding IDLE/ISSUE/WAIT

One natural sub-module, cordic_phase_acc, covers:
- accumulator
- load/increment priority
- offset add
- most-negative clamp

The FSM, pending, timer and flags stay in the top level.

Test Plan:
1. freq_word=32'h4000_0000, offset 0, five spaced ticks -> cordic_z0 = 16'h0000, 16'h4000, 16'h8001 (clamped), 16'hC000, 16'h0000. Each sin_out/cos_out equals the core output captured on finish.
2. Tick at T -> cordic_start high only at T+1. A model core with finish at start+17 -> out_valid exactly at start+18, busy low the next cycle.
3. Three ticks on consecutive cycles during WAIT -> first sets pending, second sets overrun. Pending tick issues start one cycle after IDLE return, giving exactly 2 conversions.
4. Core never asserts finish, TMO=32 -> timeout=1 after 32 WAIT cycles, IDLE, no out_valid. clr_flags -> timeout=0.
5. load_phase with phase_init=16'h2000 and a tick in the same cycle, freq 32'h0001_0000 -> z0=16'h2000, next tick z0=16'h2001. phase_offset=16'hF000 on the next tick -> z0=16'h1002.
6. reset asserted mid-WAIT -> all outputs 0 immediately. No out_valid after release. First tick after release yields z0=phase_offset.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC NCO front end: default widths, angle constants and FSM states.
package cordic_pkg;

    localparam int unsigned W_DEFAULT = 16;

    localparam logic [15:0] ANG_MOST_NEG = 16'h8000;
    localparam logic [15:0] ANG_CLAMP    = 16'h8001;
    localparam logic [15:0] ANG_QUARTER  = 16'h4000;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait
    } state_e;

endpackage

// File: rtl/cordic_phase_acc.sv
// Phase accumulator: load/increment priority, phase offset and most-negative clamp.
module cordic_phase_acc
    import cordic_pkg::*;
#(
    parameter int unsigned W  = W_DEFAULT,
    parameter int unsigned FW = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          tick_i,
    input  logic          load_i,
    input  logic [W-1:0]  phase_init_i,
    input  logic [W-1:0]  phase_offset_i,
    input  logic [FW-1:0] freq_word_i,
    output logic [W-1:0]  z0_o
);

    localparam logic [W-1:0] MostNeg = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] Clamp   = MostNeg | W'(1);

    logic [FW-1:0] acc_q, acc_d, base;
    logic [W-1:0]  z0_q, z0_d, p;

    always_comb begin
        base  = load_i ? (FW'(phase_init_i) << (FW - W)) : acc_q;
        p     = base[FW-1 -: W] + phase_offset_i;
        // The core cannot negate the most-negative angle; nudge it by one LSB.
        if (p == MostNeg) begin
            p = Clamp;
        end
        acc_d = acc_q;
        z0_d  = z0_q;
        if (tick_i) begin
            z0_d  = p;
            acc_d = base + freq_word_i;
        end else if (load_i) begin
            acc_d = base;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
            z0_q  <= '0;
        end else begin
            acc_q <= acc_d;
            z0_q  <= z0_d;
        end
    end

    assign z0_o = z0_q;

endmodule

// File: rtl/cordic_nco_ctrl.sv
// NCO front end: turns sample ticks into CORDIC start pulses and registers the core's results.
module cordic_nco_ctrl
    import cordic_pkg::*;
#(
    parameter int unsigned W   = W_DEFAULT,
    parameter int unsigned FW  = 32,
    parameter int unsigned TMO = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          enable_i,
    input  logic          sample_tick_i,
    input  logic [FW-1:0] freq_word_i,
    input  logic          load_phase_i,
    input  logic [W-1:0]  phase_init_i,
    input  logic [W-1:0]  phase_offset_i,
    input  logic          clr_flags_i,
    output logic          cordic_start_o,
    output logic [W-1:0]  cordic_z0_o,
    input  logic          cordic_finish_i,
    input  logic [W-1:0]  cordic_sin_i,
    input  logic [W-1:0]  cordic_cos_i,
    output logic [W-1:0]  sin_out_o,
    output logic [W-1:0]  cos_out_o,
    output logic          out_valid_o,
    output logic          busy_o,
    output logic          overrun_o,
    output logic          timeout_o
);

    localparam int unsigned TW = $clog2(TMO + 1);

    state_e        state_q, state_d;
    logic          pending_q, pending_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [W-1:0]  sin_q, sin_d, cos_q, cos_d;
    logic          valid_q, valid_d;
    logic          overrun_q, overrun_d;
    logic          timeout_q, timeout_d;
    logic          tick_acc;
    logic          busy;

    assign busy = (state_q == StIssue) || (state_q == StWait);

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        timer_d   = timer_q;
        sin_d     = sin_q;
        cos_d     = cos_q;
        valid_d   = 1'b0;
        overrun_d = overrun_q & ~clr_flags_i;
        timeout_d = timeout_q & ~clr_flags_i;
        tick_acc  = 1'b0;

        case (state_q)
            StIdle: begin
                if (enable_i && (sample_tick_i || pending_q)) begin
                    tick_acc  = 1'b1;
                    state_d   = StIssue;
                    // A fresh tick arriving alongside a pending one stays queued.
                    pending_d = pending_q && sample_tick_i;
                end
            end
            StIssue: begin
                state_d = StWait;
                timer_d = '0;
            end
            StWait: begin
                if (cordic_finish_i) begin
                    sin_d   = cordic_sin_i;
                    cos_d   = cordic_cos_i;
                    valid_d = 1'b1;
                    state_d = StIdle;
                end else if (timer_q == TW'(TMO - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (busy && enable_i && sample_tick_i) begin
            if (!pending_q) begin
                pending_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
        if (!enable_i) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            pending_q <= 1'b0;
            timer_q   <= '0;
            sin_q     <= '0;
            cos_q     <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            timer_q   <= timer_d;
            sin_q     <= sin_d;
            cos_q     <= cos_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
        end
    end

    cordic_phase_acc #(
        .W  (W),
        .FW (FW)
    ) u_phase_acc (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .tick_i         (tick_acc),
        .load_i         (load_phase_i),
        .phase_init_i   (phase_init_i),
        .phase_offset_i (phase_offset_i),
        .freq_word_i    (freq_word_i),
        .z0_o           (cordic_z0_o)
    );

    assign cordic_start_o = (state_q == StIssue);
    assign sin_out_o      = sin_q;
    assign cos_out_o      = cos_q;
    assign out_valid_o    = valid_q;
    assign busy_o         = busy;
    assign overrun_o      = overrun_q;
    assign timeout_o      = timeout_q;

endmodule
